// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and constants for the iterative multiply/divide unit
package muldiv_pkg;
  typedef enum logic [1:0] {MUL = 2'b00, MULU = 2'b01, DIV = 2'b10, DIVU = 2'b11} muldiv_op_t;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} muldiv_state_t;
  localparam logic [63:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract division iteration, quotient bits enter at the LSB
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  // diff[WIDTH] set means the trial subtraction went negative, so restore
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff = shifted - {1'b0, divisor};
    rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative multiply/divide for EX; define MULDIV_EARLY_OUT_EN for multiply early termination
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       rw_in,
  input  logic             flush,
  output logic             busy,
  output logic             stall_id,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic [4:0]       rw_out,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  muldiv_state_t state;
  muldiv_op_t op_r;
  logic [4:0] rw_r;
  logic sa, sb;
  logic [2*WIDTH-1:0] acc, mcand, acc_n, prod;
  logic [WIDTH-1:0] mplier, mplier_n, rem_s, quo_s, quo_f, rem_f, a_abs, b_abs;
  logic [CW-1:0] cnt;
  logic in_sa, in_sb, is_div, dz, last;

  assign busy = state == CALC;
  assign stall_id = busy;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in (acc[2*WIDTH-1:WIDTH]),
    .quo_in (acc[WIDTH-1:0]),
    .divisor(mplier),
    .rem_out(rem_s),
    .quo_out(quo_s)
  );

  // operand magnitudes, next iteration value and sign fix-up of the finishing value
  always_comb begin
    in_sa = ~op[0] & operand_a[WIDTH-1];
    in_sb = ~op[0] & operand_b[WIDTH-1];
    a_abs = in_sa ? -operand_a : operand_a;
    b_abs = in_sb ? -operand_b : operand_b;
    is_div = op_r == DIV || op_r == DIVU;
    dz = is_div && mplier == '0;
    mplier_n = mplier >> 1;
    acc_n = is_div ? {rem_s, quo_s} : acc + (mplier[0] ? mcand : '0);
    prod = (sa ^ sb) ? -acc_n : acc_n;
    quo_f = (sa ^ sb) ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    rem_f = sa ? -acc_n[2*WIDTH-1:WIDTH] : acc_n[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
    last = cnt == CW'(1) || (!is_div && mplier_n == '0);
`else
    last = cnt == CW'(1);
`endif
  end

  // control FSM, iteration datapath and registered results; in divide mode mplier holds the divisor
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_r <= MUL;
      rw_r <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      rw_out <= '0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == CALC) begin
        if (flush) begin
          state <= IDLE;
        end else if (dz) begin
          state <= DONE;
          done <= 1'b1;
          div_by_zero <= 1'b1;
          result_lo <= DIV0_QUOTIENT[WIDTH-1:0];
          result_hi <= sa ? -mcand[WIDTH-1:0] : mcand[WIDTH-1:0];
          rw_out <= rw_r;
        end else begin
          acc <= acc_n;
          mcand <= mcand << 1;
          mplier <= is_div ? mplier : mplier_n;
          cnt <= cnt - CW'(1);
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            rw_out <= rw_r;
            {result_hi, result_lo} <= is_div ? {rem_f, quo_f} : prod;
          end
        end
      end else if (flush) begin
        state <= IDLE;
      end else if (start) begin
        state <= CALC;
        op_r <= muldiv_op_t'(op);
        rw_r <= rw_in;
        sa <= in_sa;
        sb <= in_sb;
        acc <= op[1] ? {{WIDTH{1'b0}}, a_abs} : '0;
        mcand <= {{WIDTH{1'b0}}, a_abs};
        mplier <= b_abs;
        cnt <= CW'(WIDTH);
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed-vector bench for mul_div_unit (default build, MULDIV_EARLY_OUT_EN undefined)
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0] rw_in = '0;
  logic flush = 1'b0;
  logic busy, stall_id, done, div_by_zero;
  logic [31:0] result_hi, result_lo;
  logic [4:0] rw_out;
  int checks = 0;
  int failures = 0;
  int lat, stalls, seen;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .rw_in(rw_in), .flush(flush),
    .busy(busy), .stall_id(stall_id), .done(done),
    .result_hi(result_hi), .result_lo(result_lo), .rw_out(rw_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rw);
    @(negedge clk);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    rw_in = rw;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int l, output int s);
    l = 0;
    s = 0;
    while (!done && l < 100) begin
      if (stall_id) s++;
      @(posedge clk);
      #1 l++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stall"}, stall_id, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
    check({tag, "_res"}, {result_hi, result_lo}, 0);
    check({tag, "_rw"}, rw_out, 0);
  endtask

  initial begin
    #3 reset = 1'b0;
    #10 check_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    issue(2'b00, 32'd7, 32'hFFFFFFFD, 5'd3);
    wait_done(lat, stalls);
    check("mul_lat", lat, 32);
    check("mul_stall", stalls, 32);
    check("mul_res", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFEB);
    check("mul_rw", rw_out, 3);
    check("mul_dbz", div_by_zero, 0);
    @(posedge clk);
    #1 check("mul_pulse", {busy, done}, 0);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
    wait_done(lat, stalls);
    check("mulu_res", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);
    issue(2'b11, 32'd100, 32'd7, 5'd5);
    wait_done(lat, stalls);
    check("b2b_lat", lat, 32);
    check("divu_res", {result_hi, result_lo}, {32'd2, 32'd14});
    check("divu_rw", rw_out, 5);

    issue(2'b10, 32'hFFFFFFF9, 32'd2, 5'd6);
    wait_done(lat, stalls);
    check("div_neg", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd7);
    wait_done(lat, stalls);
    check("div_ovf", {result_hi, result_lo}, 64'h00000000_80000000);

    issue(2'b11, 32'd100, 32'd0, 5'd9);
    wait_done(lat, stalls);
    check("dz_lat", lat, 1);
    check("dz_res", {result_hi, result_lo}, {32'd100, 32'hFFFFFFFF});
    check("dz_flag", div_by_zero, 1);
    check("dz_rw", rw_out, 9);
    @(posedge clk);
    #1 check("dz_flag_clr", {done, div_by_zero}, 0);

    issue(2'b10, 32'hFFFFFFF0, 32'd0, 5'd10);
    wait_done(lat, stalls);
    check("sdz_res", {result_hi, result_lo}, 64'hFFFFFFF0_FFFFFFFF);

    issue(2'b01, 32'd3, 32'd4, 5'd13);
    @(negedge clk);
    start = 1'b1;
    op = 2'b11;
    operand_a = 32'd1;
    operand_b = 32'd0;
    rw_in = 5'd14;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, stalls);
    check("ign_lat", lat, 31);
    check("ign_res", {result_hi, result_lo}, 64'd12);
    check("ign_rw", rw_out, 13);
    check("ign_dbz", div_by_zero, 0);

    issue(2'b00, 32'd5, 32'd6, 5'd11);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", {busy, stall_id}, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    check("flush_nodone", seen, 0);
    check("flush_hold", {result_hi, result_lo}, 64'd12);
    check("flush_rw", rw_out, 13);

    issue(2'b00, 32'd9, 32'd9, 5'd20);
    @(negedge clk);
    flush = 1'b1;
    issue(2'b01, 32'd2, 32'd2, 5'd21);
    flush = 1'b0;
    check("flush_start", {busy, done}, 0);

    issue(2'b01, 32'd1, 32'd2, 5'd15);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_zero("arst");
    @(negedge clk);
    reset = 1'b1;
    issue(2'b01, 32'd3, 32'd5, 5'd16);
    wait_done(lat, stalls);
    check("post_rst_lat", lat, 32);
    check("post_rst_res", {result_hi, result_lo}, 64'd15);
    check("post_rst_rw", rw_out, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
